// File: rtl/sram_2114_controller.sv
// Host request/ack front end for a parallel bank of 2114 1Kx4 static RAMs.
// Sequences address setup, CS_n/WE_n strobes and data-bus ownership from flops only.
module sram_2114_controller #(
  parameter int CHIPS         = 2,
  parameter int SETUP_CYCLES  = 1,
  parameter int ACCESS_CYCLES = 4,
  localparam int unsigned DW  = 4 * CHIPS
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic          we,
  input  logic [9:0]    addr,
  input  logic [DW-1:0] wdata,
  output logic          ready,
  output logic          ack,
  output logic [DW-1:0] rdata,
  output logic [9:0]    sram_addr,
  inout  tri   [DW-1:0] sram_dq,
  output logic          sram_cs_n,
  output logic          sram_we_n
);

  localparam int unsigned MAXC = (SETUP_CYCLES > ACCESS_CYCLES) ?
                                 32'(SETUP_CYCLES) : 32'(ACCESS_CYCLES);
  localparam int unsigned CW   = $clog2(MAXC + 1);

  if (SETUP_CYCLES < 1 || ACCESS_CYCLES < 1) begin : g_bad_timing
    $error("sram_2114_controller: SETUP_CYCLES and ACCESS_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_RECOVER
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [9:0]      addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            we_q, we_d;
  logic            cs_n_q, cs_n_d;
  logic            we_n_q, we_n_d;
  logic            oe_q, oe_d;
  logic            ack_q, ack_d;
  logic            ready_q, ready_d;

  // Pin values are computed for the state being entered, so every pin is a flop output.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    rdata_d = rdata_q;
    cs_n_d  = 1'b1;
    we_n_d  = 1'b1;
    oe_d    = 1'b0;
    ack_d   = 1'b0;
    ready_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req && ready_q) begin
          state_d = ST_SETUP;
          cnt_d   = CW'(SETUP_CYCLES - 1);
          addr_d  = addr;
          wdata_d = wdata;
          we_d    = we;
          oe_d    = we;
        end else begin
          ready_d = 1'b1;
        end
      end
      ST_SETUP: begin
        oe_d = we_q;
        if (cnt_q == '0) begin
          state_d = ST_ACCESS;
          cnt_d   = CW'(ACCESS_CYCLES - 1);
          cs_n_d  = 1'b0;
          we_n_d  = ~we_q;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_ACCESS: begin
        oe_d = we_q;
        if (cnt_q == '0) begin
          state_d = ST_RECOVER;
          ack_d   = 1'b1;
          if (!we_q) rdata_d = sram_dq;
        end else begin
          cnt_d  = cnt_q - CW'(1);
          cs_n_d = 1'b0;
          we_n_d = ~we_q;
        end
      end
      ST_RECOVER: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
      cs_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      oe_q    <= 1'b0;
      ack_q   <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
      cs_n_q  <= cs_n_d;
      we_n_q  <= we_n_d;
      oe_q    <= oe_d;
      ack_q   <= ack_d;
      ready_q <= ready_d;
    end
  end

  assign sram_dq   = oe_q ? wdata_q : {DW{1'bz}};
  assign sram_addr = addr_q;
  assign sram_cs_n = cs_n_q;
  assign sram_we_n = we_n_q;
  assign ack       = ack_q;
  assign ready     = ready_q;
  assign rdata     = rdata_q;

endmodule

// File: tb/tb_sram_2114_controller.sv
// Directed and random checks of sram_2114_controller against a two-chip 2114 bus model.
module tb_sram_2114_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       req;
  logic       we;
  logic [9:0] addr;
  logic [7:0] wdata;
  logic       ready;
  logic       ack;
  logic [7:0] rdata;
  logic [9:0] sram_addr;
  wire  [7:0] sram_dq;
  logic       sram_cs_n;
  logic       sram_we_n;

  always #5 clk = ~clk;

  sram_2114_controller #(.CHIPS(2), .SETUP_CYCLES(1), .ACCESS_CYCLES(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
    .ready     (ready),
    .ack       (ack),
    .rdata     (rdata),
    .sram_addr (sram_addr),
    .sram_dq   (sram_dq),
    .sram_cs_n (sram_cs_n),
    .sram_we_n (sram_we_n)
  );

  // Undriven bus floats high, so a released bus reads 0xFF.
  for (genvar i = 0; i < 8; i++) begin : g_pu
    pullup (sram_dq[i]);
  end

  // Two 2114 devices: low and high nibble.
  logic [3:0] mem_lo [1024];
  logic [3:0] mem_hi [1024];

  assign sram_dq = (!sram_cs_n && sram_we_n) ? {mem_hi[sram_addr], mem_lo[sram_addr]} : 8'bz;

  always @(sram_cs_n or sram_we_n or sram_addr or sram_dq) begin
    if (sram_cs_n === 1'b0 && sram_we_n === 1'b0) begin
      mem_lo[sram_addr] = sram_dq[3:0];
      mem_hi[sram_addr] = sram_dq[7:4];
    end
  end

  int         n_checks = 0;
  int         n_pass   = 0;
  int         viol     = 0;
  logic       prev_cs_low = 1'b0;
  logic [9:0] prev_addr   = '0;

  // Strobe ordering, address stability and read-contention monitor.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (sram_we_n === 1'b0 && sram_cs_n === 1'b1) viol <= viol + 1;
      if (sram_cs_n === 1'b0 && prev_cs_low && sram_addr !== prev_addr) viol <= viol + 1;
      if (sram_cs_n === 1'b0 && sram_we_n === 1'b1 &&
          sram_dq !== {mem_hi[sram_addr], mem_lo[sram_addr]}) viol <= viol + 1;
    end
    prev_cs_low <= (sram_cs_n === 1'b0);
    prev_addr   <= sram_addr;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  logic [7:0] sb       [1024];
  bit         sb_valid [1024];
  logic [7:0] last_rdata;

  // One host transaction, started at a negedge; returns at the negedge of the IDLE cycle.
  task automatic do_op(input bit w, input logic [9:0] a, input logic [7:0] d,
                       input bit hold, input bit inject, input string tag);
    int waited = 0;
    int ack_cyc = 0;
    int ack_n = 0;
    while (ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check_eq({tag, "_ready"}, 32'(ready), 32'(1'b1));
    req = 1'b1; we = w; addr = a; wdata = d;
    @(posedge clk);
    #1;
    if (!hold) req = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (ack === 1'b1) begin
        ack_n++;
        ack_cyc = c;
      end
      if (c == 1) check_eq({tag, "_busy"}, 32'(ready), 32'(1'b0));
      if (!w && (c == 1 || c == 6)) check_eq({tag, "_dq_released"}, 32'(sram_dq), 32'(8'hFF));
      if (w && c == 3) begin
        check_eq({tag, "_strobes"}, 32'({sram_cs_n, sram_we_n}), 32'(2'b00));
        check_eq({tag, "_dq_drv"}, 32'(sram_dq), 32'(d));
      end
      if (!w && c == 3) check_eq({tag, "_rd_strobes"}, 32'({sram_cs_n, sram_we_n}), 32'(2'b01));
      if (inject && c == 3) begin
        req = 1'b1; we = 1'b1; addr = 10'h100; wdata = 8'h11;
      end
      if (inject && c == 5) req = 1'b0;
    end
    check_eq({tag, "_ack_cycle"}, 32'(ack_cyc), 32'(6));
    check_eq({tag, "_ack_width"}, 32'(ack_n), 32'(1));
    if (w) begin
      check_eq({tag, "_rdata_kept"}, 32'(rdata), 32'(last_rdata));
      sb[a] = d;
      sb_valid[a] = 1'b1;
    end else if (sb_valid[a]) begin
      check_eq({tag, "_rdata"}, 32'(rdata), 32'(sb[a]));
      last_rdata = sb[a];
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    last_rdata = 8'h00;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("rst_ctrl", 32'({sram_cs_n, sram_we_n, ack, ready}), 32'(4'b1100));
      check_eq("rst_dq", 32'(sram_dq), 32'(8'hFF));
      check_eq("rst_data", 32'({sram_addr, rdata}), 32'(18'h0));
    end
    reset = 1'b0;
    @(negedge clk);
    check_eq("ready_after_rst", 32'(ready), 32'(1'b1));

    do_op(1'b1, 10'h000, 8'hA5, 1'b0, 1'b0, "wr_a5");
    do_op(1'b0, 10'h000, 8'h3C, 1'b0, 1'b0, "rd_a5");

    do_op(1'b1, 10'h3FF, 8'hFF, 1'b1, 1'b0, "b2b_wr_3ff");
    do_op(1'b1, 10'h001, 8'h5A, 1'b1, 1'b0, "b2b_wr_001");
    do_op(1'b0, 10'h3FF, 8'h00, 1'b1, 1'b0, "b2b_rd_3ff");
    do_op(1'b0, 10'h001, 8'h00, 1'b0, 1'b0, "b2b_rd_001");

    do_op(1'b1, 10'h100, 8'h22, 1'b0, 1'b0, "wr_100");
    do_op(1'b1, 10'h200, 8'h77, 1'b0, 1'b0, "wr_200");
    do_op(1'b0, 10'h200, 8'h00, 1'b0, 1'b1, "rd_200_inject");
    do_op(1'b0, 10'h100, 8'h00, 1'b0, 1'b0, "rd_100_untouched");

    // Abort a write with reset during its second ACCESS cycle.
    begin
      int acks = 0;
      req = 1'b1; we = 1'b1; addr = 10'h300; wdata = 8'hEE;
      @(posedge clk);
      #1;
      req = 1'b0;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check_eq("abort_ctrl", 32'({sram_cs_n, sram_we_n, ack, ready}), 32'(4'b1100));
      check_eq("abort_dq", 32'(sram_dq), 32'(8'hFF));
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        if (ack === 1'b1) acks++;
      end
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        if (ack === 1'b1) acks++;
      end
      check_eq("abort_no_ack", 32'(acks), 32'(0));
      check_eq("abort_ready", 32'(ready), 32'(1'b1));
      check_eq("abort_rdata", 32'(rdata), 32'(8'h00));
      last_rdata = 8'h00;
      sb_valid[10'h300] = 1'b0;
    end

    for (int n = 0; n < 200; n++) begin
      logic [9:0] a;
      logic [7:0] d;
      bit         w;
      a = 10'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) a = a | 10'h3F8;
      d = 8'($urandom_range(0, 255));
      w = !sb_valid[a] || ($urandom_range(0, 1) == 1);
      do_op(w, a, d, 1'b0, 1'b0, w ? "rnd_wr" : "rnd_rd");
    end

    check_eq("bus_rules", 32'(viol), 32'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
